// File: rtl/ring_rotor_if.sv
// Control and status bundle between a ring_rotor_sequencer and its host.
// The host drives run requests and parameters; the sequencer reports ring state.
interface ring_rotor_if #(
  parameter int WIDTH = 3,
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);

  logic             start;
  logic             stop;
  logic [WIDTH-1:0] pattern;
  logic             dir;
  logic [DIV_W-1:0] divisor;
  logic [CNT_W-1:0] steps;

  logic [WIDTH-1:0] ring_q;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             tick;

  modport master (
    output start,
    output stop,
    output pattern,
    output dir,
    output divisor,
    output steps,
    input  ring_q,
    input  count,
    input  busy,
    input  done,
    input  tick
  );

  modport slave (
    input  start,
    input  stop,
    input  pattern,
    input  dir,
    input  divisor,
    input  steps,
    output ring_q,
    output count,
    output busy,
    output done,
    output tick
  );

endinterface

// File: rtl/ring_rotor_sequencer.sv
// Ring register sequencer: load on start, prescaled rotation, stop after a
// programmed step count or on request.
module ring_rotor_sequencer #(
  parameter int WIDTH = 3,
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  ring_rotor_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] ring_q;
  logic [CNT_W-1:0] count_q;
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] div_l_q;
  logic [CNT_W-1:0] steps_l_q;
  logic             dir_l_q;
  logic             busy_q;
  logic             done_q;
  logic             tick_q;

  logic [WIDTH-1:0] ring_d;
  logic [CNT_W-1:0] count_d;
  logic [DIV_W-1:0] presc_d;
  logic             term;
  logic             last;

  assign term    = (presc_q == div_l_q);
  assign count_d = count_q + CNT_W'(1);
  assign presc_d = presc_q + DIV_W'(1);
  // steps_l of zero means free-run; only stop can end it
  assign last    = (steps_l_q != '0) && (count_d == steps_l_q);

  always_comb begin
    ring_d = ring_q;
    if (dir_l_q) begin
      ring_d = {ring_q[0], ring_q[WIDTH-1:1]};
    end else begin
      ring_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ring_q    <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      div_l_q   <= '0;
      steps_l_q <= '0;
      dir_l_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          ring_q    <= bus.pattern;
          div_l_q   <= bus.divisor;
          steps_l_q <= bus.steps;
          dir_l_q   <= bus.dir;
          presc_q   <= '0;
          count_q   <= '0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          // stop wins over a rotation due on the same edge
          if (bus.stop) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (term) begin
            ring_q  <= ring_d;
            presc_q <= '0;
            count_q <= count_d;
            tick_q  <= 1'b1;
            if (last) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            presc_q <= presc_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ring_q = ring_q;
  assign bus.count  = count_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.tick   = tick_q;

endmodule

// File: tb/tb_ring_rotor_sequencer.sv
// Directed bench for ring_rotor_sequencer: vector table plus
// hand-written free-run, wrap, collision and async-reset sequences.
module tb_ring_rotor_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ring_rotor_if #(.WIDTH(3), .DIV_W(8), .CNT_W(8)) bus ();

  ring_rotor_sequencer #(.WIDTH(3), .DIV_W(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       pat;
    logic             dir;
    logic [7:0]       div;
    logic [7:0]       steps;
    logic [3:0][2:0]  seq;
    int               lat;
  } vec_t;

  vec_t vt[6];

  function automatic vec_t mk(input logic [2:0] p, input logic d,
                              input logic [7:0] dv, input logic [7:0] st,
                              input logic [2:0] s0, input logic [2:0] s1,
                              input logic [2:0] s2, input logic [2:0] s3,
                              input int lat);
    vec_t v;
    v.pat    = p;
    v.dir    = d;
    v.div    = dv;
    v.steps  = st;
    v.seq[0] = s0;
    v.seq[1] = s1;
    v.seq[2] = s2;
    v.seq[3] = s3;
    v.lat    = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [2:0] p, input logic d,
                      input logic [7:0] dv, input logic [7:0] st);
    bus.pattern = p;
    bus.dir     = d;
    bus.divisor = dv;
    bus.steps   = st;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int ticks;
    int n;
    bit got;
    ticks = 0;
    got   = 0;
    kick(v.pat, v.dir, v.div, v.steps);
    chk({nm, " busy@N"}, 32'(bus.busy), 32'd1);
    step();
    chk({nm, " load"}, 32'(bus.ring_q), 32'(v.pat));
    chk({nm, " tick@load"}, 32'(bus.tick), 32'd0);
    n = 1;
    while (!got && n < 600) begin
      step();
      n++;
      if (bus.tick) begin
        if (ticks < 4) chk({nm, " seq"}, 32'(bus.ring_q), 32'(v.seq[ticks]));
        ticks++;
      end
      if (bus.done) got = 1;
    end
    chk({nm, " done seen"}, 32'(got), 32'd1);
    chk({nm, " latency"}, 32'(n), 32'(v.lat));
    chk({nm, " ticks"}, 32'(ticks), 32'(v.steps));
    chk({nm, " count"}, 32'(bus.count), 32'(v.steps));
    chk({nm, " busy@E"}, 32'(bus.busy), 32'd0);
    step();
    chk({nm, " done 1cyc"}, 32'(bus.done), 32'd0);
    chk({nm, " tick idle"}, 32'(bus.tick), 32'd0);
    chk({nm, " hold ring"}, 32'(bus.ring_q), 32'(v.seq[v.steps-1]));
  endtask

  task automatic wait_ticks(input int want, input string nm);
    int ticks;
    int n;
    ticks = 0;
    n     = 0;
    while (ticks < want && n < 2000) begin
      step();
      n++;
      if (bus.tick) ticks++;
    end
    chk({nm, " tick wait"}, 32'(ticks), 32'(want));
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b1;
    bus.stop    = 1'b0;
    bus.pattern = 3'b101;
    bus.dir     = 1'b0;
    bus.divisor = 8'd0;
    bus.steps   = 8'd0;

    vt[0] = mk(3'b001, 1'b0, 8'd0, 8'd3, 3'b010, 3'b100, 3'b001, 3'b000, 4);
    vt[1] = mk(3'b001, 1'b1, 8'd2, 8'd2, 3'b100, 3'b010, 3'b000, 3'b000, 7);
    vt[2] = mk(3'b110, 1'b0, 8'd1, 8'd4, 3'b101, 3'b011, 3'b110, 3'b101, 9);
    vt[3] = mk(3'b111, 1'b1, 8'd0, 8'd2, 3'b111, 3'b111, 3'b000, 3'b000, 3);
    vt[4] = mk(3'b000, 1'b0, 8'd3, 8'd1, 3'b000, 3'b000, 3'b000, 3'b000, 5);
    vt[5] = mk(3'b100, 1'b1, 8'd0, 8'd3, 3'b010, 3'b001, 3'b100, 3'b000, 4);

    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst ring", 32'(bus.ring_q), 32'd0);
      chk("rst count", 32'(bus.count), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst tick", 32'(bus.tick), 32'd0);
    end
    bus.start = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("idle busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
    end

    // free-run, stop lands on a terminal-count edge (div=0)
    kick(3'b001, 1'b0, 8'd0, 8'd0);
    step();
    wait_ticks(5, "free");
    chk("free ring5", 32'(bus.ring_q), 32'b100);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop done", 32'(bus.done), 32'd1);
    chk("stop tick", 32'(bus.tick), 32'd0);
    chk("stop ring", 32'(bus.ring_q), 32'b100);
    chk("stop count", 32'(bus.count), 32'd5);
    chk("stop busy", 32'(bus.busy), 32'd0);
    step();
    chk("stop done 1cyc", 32'(bus.done), 32'd0);
    chk("stop hold", 32'(bus.ring_q), 32'b100);

    // 256 rotations without stop: count wraps, run continues
    kick(3'b001, 1'b0, 8'd0, 8'd0);
    step();
    wait_ticks(255, "wrap");
    chk("wrap 255", 32'(bus.count), 32'd255);
    step();
    chk("wrap 0", 32'(bus.count), 32'd0);
    chk("wrap tick", 32'(bus.tick), 32'd1);
    chk("wrap busy", 32'(bus.busy), 32'd1);
    chk("wrap ring", 32'(bus.ring_q), 32'b010);
    step();
    chk("wrap 1", 32'(bus.count), 32'd1);
    chk("wrap done", 32'(bus.done), 32'd0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("wrap stop", 32'(bus.done), 32'd1);
    step();

    // start during RUN and during DONE is ignored
    kick(3'b001, 1'b0, 8'd2, 8'd2);
    step();
    wait_ticks(1, "coll");
    chk("coll r1", 32'(bus.ring_q), 32'b010);
    bus.pattern = 3'b111;
    bus.divisor = 8'd0;
    bus.steps   = 8'd0;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
    chk("coll noload", 32'(bus.ring_q), 32'b010);
    chk("coll busy", 32'(bus.busy), 32'd1);
    begin
      int n;
      n = 0;
      while (!bus.done && n < 50) begin
        step();
        n++;
      end
      chk("coll cycles", 32'(n), 32'd2);
    end
    chk("coll ring", 32'(bus.ring_q), 32'b100);
    chk("coll count", 32'(bus.count), 32'd2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("coll done start", 32'(bus.busy), 32'd0);
    step();
    chk("coll noqueue", 32'(bus.busy), 32'd0);
    chk("coll hold", 32'(bus.ring_q), 32'b100);

    // async reset between edges
    kick(3'b001, 1'b0, 8'd5, 8'd0);
    step();
    wait_ticks(1, "arst");
    chk("arst pre tick", 32'(bus.tick), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst ring", 32'(bus.ring_q), 32'd0);
    chk("arst count", 32'(bus.count), 32'd0);
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst tick", 32'(bus.tick), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("arst idle", 32'(bus.busy), 32'd0);
    run_vec(vt[0], "post-rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_rotor_sequencer.md
# ring_rotor_sequencer

Self-contained sequencer that owns a WIDTH-bit ring register and drives it through load, timed rotation and stop phases. A start pulse loads a pattern, a programmable prescaler paces the rotation, and the block stops after a programmed step count or on request. It replaces direct pin-level load/rotate control of the ring, so the 7-segment mapping logic downstream sees a stable, rate-controlled pattern.

## Interface
- WIDTH, 3, ring register width (≥2)
- DIV_W, 8, prescaler divisor width
- CNT_W, 8, step counter width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level sampled each edge; starts a run from IDLE
- stop  in  1  level sampled each edge; ends a run from RUN
- pattern  in  WIDTH  value loaded into the ring on start
- dir  in  1  0 = rotate left (bit0←bit WIDTH-1), 1 = rotate right (bit WIDTH-1←bit0)
- divisor  in  DIV_W  rotation period minus one, in cycles
- steps  in  CNT_W  rotations per run; 0 = free-run until stop
- ring_q  out  WIDTH  ring register contents
- count  out  CNT_W  rotations since last load
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse in DONE
- tick  out  1  one-cycle pulse, high in the cycle after each rotation

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset (rst_n low, asynchronous) → IDLE, ring_q=0, count=0, prescaler=0, busy=0, done=0, tick=0.
- IDLE: start=1 → LOAD. stop is ignored. start+stop together → LOAD.
- LOAD (one cycle): at the exit edge, ring_q←pattern, div_l←divisor, steps_l←steps, dir_l←dir, prescaler←0, count←0; → RUN. pattern, divisor, steps and dir are sampled only here.
- RUN, each edge, in priority order:
  - stop=1 → DONE. No rotation occurs on that edge, even if the prescaler is at terminal count.
  - prescaler==div_l → rotate ring_q per dir_l, prescaler←0, count←count+1 (wraps modulo 2^CNT_W), tick←1. If steps_l≠0 and count+1==steps_l → DONE.
  - Otherwise prescaler←prescaler+1.
- DONE (one cycle): done=1; → IDLE. ring_q and count hold until the next LOAD.
- start in LOAD, RUN or DONE is ignored. It does not queue.
- Rotation example for WIDTH=3: left 001→010→100→001; right 001→100→010→001.
- A ring_q of all-zeros or all-ones rotates to itself and is legal.

## Timing
- start high at edge N: busy=1 after N, ring_q=pattern after N+1.
- Rotations occur at edges N+2+div_l, then every div_l+1 cycles. div_l=0 rotates every cycle.
- The final rotation and the RUN→DONE transition happen on the same edge E. done is high for the cycle after E. busy falls after E, and the state is IDLE after E+1.
- A new start is accepted no earlier than the edge that leaves DONE+1, i.e. when the state is IDLE.
- tick is registered: it is high for exactly one cycle following each rotation edge and is coincident with the updated ring_q. tick is never high at the same time as a LOAD update.
- Reset asserted mid-run clears all state immediately without waiting for a clock edge. After rst_n rises, the first edge sees IDLE.

## Test plan
- Reset: hold rst_n=0 with clk toggling and start=1 → ring_q=0, count=0, busy=0, done=0, tick=0 throughout.
- pattern=001, dir=0, divisor=0, steps=3, start pulse at edge N → ring_q 001 (N+1), 010 (N+2), 100 (N+3), 001 (N+4). tick is high for three cycles. done is high for the single cycle after N+4. count=3. busy is low after N+4.
- pattern=001, dir=1, divisor=2, steps=2 → rotations at N+4 and N+7 give ring_q 100 then 010. Exactly 2 tick pulses and 1 done pulse.
- Free-run: steps=0, divisor=0, stop raised after 5 ticks → ring_q frozen, count=5, one done pulse. Run 256 rotations without stop → count wraps 255→0 and the run continues.
- Collision cases:
  - start pulsed during RUN → no reload, and the run completes unchanged.
  - stop asserted on a terminal-count edge → no rotation, count unchanged, DONE follows.
- Async reset: drop rst_n mid-RUN between clock edges → outputs are zero before the next edge. After release, a start runs normally.
